rd_way_sel_pipe: RTL and testbench

Parametrised read-data way-select pipeline for the usclk domain. It registers a way select at stage s3 and delivers the selected way's data at stage s4, extending the fixed two-way, single-width select to NWAY ways of DW bits. It adds three things the two-way version lacks: a valid pipeline, sticky first-error capture on per-way parity flags, and a HDEPTH-entry history of delivered words for debug readout.

---
 rtl/rd_way_sel_pipe.sv | 136 +++++++++++++
 tb/tb_rd_way_sel_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_way_sel_pipe.sv
// Read-data way-select pipeline: the select is registered at s3, the chosen way is delivered at s4.
// Includes sticky first-error capture on the selected way's parity flag and a history of delivered words.
module rd_way_sel_pipe #(
  parameter int DW      = 6,
  parameter int NWAY    = 4,
  parameter int HDEPTH  = 10,
  localparam int SELW   = ($clog2(NWAY) > 1) ? $clog2(NWAY) : 1,
  localparam int CNTW   = $clog2(HDEPTH + 1)
) (
  input  logic                   usclk,
  input  logic                   sso_srst_n,
  input  logic                   rd_vld_s2,
  input  logic [SELW-1:0]        adr_s2,
  input  logic [NWAY*DW-1:0]     rd_dat_s3,
  input  logic [NWAY-1:0]        rd_par_s3,
  input  logic                   err_clr,
  output logic                   rd_vld_s4,
  output logic [DW-1:0]          rd_dat_s4,
  output logic                   err_vld,
  output logic [SELW-1:0]        err_way,
  output logic [DW-1:0]          err_dat,
  output logic [HDEPTH*DW-1:0]   hist_dat,
  output logic [CNTW-1:0]        hist_cnt
);

  typedef enum logic {ERR_IDLE = 1'b0, ERR_HELD = 1'b1} err_state_e;

  logic [SELW-1:0] sel_s3_q;
  logic            vld_s3_q;
  logic            rd_vld_s4_q;
  logic [DW-1:0]   rd_dat_s4_q;
  logic [DW-1:0]   rd_dat_s4_d;
  err_state_e      err_state_q;
  logic [SELW-1:0] err_way_q;
  logic [DW-1:0]   err_dat_q;
  logic [DW-1:0]   hist_q [HDEPTH];
  logic [DW-1:0]   hist_d [HDEPTH];
  logic [CNTW-1:0] hist_cnt_q;
  logic [CNTW-1:0] hist_cnt_d;
  logic [DW-1:0]   sdat;
  logic            perr;
  logic            err_set;

  // s3 -> s4: way mux; a select with no matching way yields zero data and counts as an error
  always_comb begin
    sdat = '0;
    perr = 1'b1;
    for (int k = 0; k < NWAY; k++) begin
      if (sel_s3_q == SELW'(k)) begin
        sdat = rd_dat_s3[k*DW +: DW];
        perr = rd_par_s3[k];
      end
    end
  end

  assign err_set = vld_s3_q & perr;

  always_comb begin
    rd_dat_s4_d = vld_s3_q ? sdat : rd_dat_s4_q;
    hist_cnt_d  = hist_cnt_q;
    for (int i = 0; i < HDEPTH; i++) begin
      hist_d[i] = hist_q[i];
    end
    if (vld_s3_q) begin
      hist_d[0] = sdat;
      for (int i = 1; i < HDEPTH; i++) begin
        hist_d[i] = hist_q[i-1];
      end
      if (hist_cnt_q != CNTW'(HDEPTH)) begin
        hist_cnt_d = hist_cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge usclk or negedge sso_srst_n) begin
    if (!sso_srst_n) begin
      sel_s3_q    <= '0;
      vld_s3_q    <= 1'b0;
      rd_vld_s4_q <= 1'b0;
      rd_dat_s4_q <= '0;
      hist_cnt_q  <= '0;
      for (int i = 0; i < HDEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      sel_s3_q    <= adr_s2;
      vld_s3_q    <= rd_vld_s2;
      rd_vld_s4_q <= vld_s3_q;
      rd_dat_s4_q <= rd_dat_s4_d;
      hist_cnt_q  <= hist_cnt_d;
      for (int i = 0; i < HDEPTH; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  // Error capture: a new error coinciding with err_clr always wins over the clear
  always_ff @(posedge usclk or negedge sso_srst_n) begin
    if (!sso_srst_n) begin
      err_state_q <= ERR_IDLE;
      err_way_q   <= '0;
      err_dat_q   <= '0;
    end else begin
      case (err_state_q)
        ERR_IDLE: begin
          if (err_set) begin
            err_state_q <= ERR_HELD;
            err_way_q   <= sel_s3_q;
            err_dat_q   <= sdat;
          end
        end
        ERR_HELD: begin
          if (err_set && err_clr) begin
            err_way_q <= sel_s3_q;
            err_dat_q <= sdat;
          end else if (err_clr) begin
            err_state_q <= ERR_IDLE;
          end
        end
        default: err_state_q <= ERR_IDLE;
      endcase
    end
  end

  assign rd_vld_s4 = rd_vld_s4_q;
  assign rd_dat_s4 = rd_dat_s4_q;
  assign err_vld   = (err_state_q == ERR_HELD);
  assign err_way   = err_way_q;
  assign err_dat   = err_dat_q;
  assign hist_cnt  = hist_cnt_q;

  for (genvar g = 0; g < HDEPTH; g++) begin : g_hist
    assign hist_dat[g*DW +: DW] = hist_q[g];
  end

endmodule

// File: tb/tb_rd_way_sel_pipe.sv
// Bench for rd_way_sel_pipe: a 4-way and a 3-way instance share stimulus and are compared
// every cycle against a transaction-level model (delivered-word log plus error record).
module tb_rd_way_sel_pipe;

  localparam int HD = 10;

  logic        usclk = 1'b0;
  logic        sso_srst_n = 1'b1;
  logic        rd_vld_s2 = 1'b0;
  logic [1:0]  adr_s2 = '0;
  logic [23:0] rd_dat_s3 = '0;
  logic [3:0]  rd_par_s3 = '0;
  logic        err_clr = 1'b0;

  wire [1:0]        o_vld;
  wire [1:0][5:0]   o_dat;
  wire [1:0]        o_errv;
  wire [1:0][1:0]   o_errway;
  wire [1:0][5:0]   o_errdat;
  wire [1:0][59:0]  o_hist;
  wire [1:0][3:0]   o_cnt;

  always #5 usclk = ~usclk;

  rd_way_sel_pipe #(.DW(6), .NWAY(4), .HDEPTH(HD)) u_w4 (
    .usclk(usclk), .sso_srst_n(sso_srst_n), .rd_vld_s2(rd_vld_s2), .adr_s2(adr_s2),
    .rd_dat_s3(rd_dat_s3), .rd_par_s3(rd_par_s3), .err_clr(err_clr),
    .rd_vld_s4(o_vld[0]), .rd_dat_s4(o_dat[0]), .err_vld(o_errv[0]), .err_way(o_errway[0]),
    .err_dat(o_errdat[0]), .hist_dat(o_hist[0]), .hist_cnt(o_cnt[0]));

  rd_way_sel_pipe #(.DW(6), .NWAY(3), .HDEPTH(HD)) u_w3 (
    .usclk(usclk), .sso_srst_n(sso_srst_n), .rd_vld_s2(rd_vld_s2), .adr_s2(adr_s2),
    .rd_dat_s3(rd_dat_s3[17:0]), .rd_par_s3(rd_par_s3[2:0]), .err_clr(err_clr),
    .rd_vld_s4(o_vld[1]), .rd_dat_s4(o_dat[1]), .err_vld(o_errv[1]), .err_way(o_errway[1]),
    .err_dat(o_errdat[1]), .hist_dat(o_hist[1]), .hist_cnt(o_cnt[1]));

  // Reference model state
  logic       m_vld3;
  logic [1:0] m_sel3;
  logic [1:0] m_vld4;
  logic [1:0] m_errv;
  logic [5:0] m_dat4 [2];
  logic [5:0] m_errdat [2];
  logic [1:0] m_errway [2];
  logic [5:0] log0 [$];
  logic [5:0] log1 [$];

  int n_chk = 0;
  int n_err = 0;

  function automatic int nw(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic int log_size(input int i);
    return (i == 0) ? log0.size() : log1.size();
  endfunction

  function automatic logic [63:0] exp_cnt(input int i);
    int n;
    n = log_size(i);
    return 64'((n > HD) ? HD : n);
  endfunction

  function automatic logic [63:0] exp_hist(input int i);
    logic [63:0] hv;
    int n;
    hv = '0;
    n = log_size(i);
    for (int k = 0; k < HD; k++) begin
      if (k < n) hv[k*6 +: 6] = (i == 0) ? log0[n-1-k] : log1[n-1-k];
    end
    return hv;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld3 = 1'b0;
    m_sel3 = '0;
    m_vld4 = '0;
    m_errv = '0;
    for (int i = 0; i < 2; i++) begin
      m_dat4[i]   = '0;
      m_errdat[i] = '0;
      m_errway[i] = '0;
    end
    log0.delete();
    log1.delete();
  endtask

  // One rising edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    logic [5:0] sd;
    logic       pe;
    for (int i = 0; i < 2; i++) begin
      if (int'(m_sel3) < nw(i)) begin
        sd = rd_dat_s3[int'(m_sel3)*6 +: 6];
        pe = rd_par_s3[m_sel3];
      end else begin
        sd = '0;
        pe = 1'b1;
      end
      m_vld4[i] = m_vld3;
      if (m_vld3) begin
        m_dat4[i] = sd;
        if (i == 0) log0.push_back(sd);
        else        log1.push_back(sd);
      end
      if (m_vld3 && pe && (!m_errv[i] || err_clr)) begin
        m_errv[i]   = 1'b1;
        m_errway[i] = m_sel3;
        m_errdat[i] = sd;
      end else if (err_clr) begin
        m_errv[i] = 1'b0;
      end
    end
    m_vld3 = rd_vld_s2;
    m_sel3 = adr_s2;
  endtask

  task automatic compare_all(input string ph);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.u%0d.vld4", ph, i), 64'(o_vld[i]), 64'(m_vld4[i]));
      chk($sformatf("%s.u%0d.dat4", ph, i), 64'(o_dat[i]), 64'(m_dat4[i]));
      chk($sformatf("%s.u%0d.errv", ph, i), 64'(o_errv[i]), 64'(m_errv[i]));
      chk($sformatf("%s.u%0d.errway", ph, i), 64'(o_errway[i]), 64'(m_errway[i]));
      chk($sformatf("%s.u%0d.errdat", ph, i), 64'(o_errdat[i]), 64'(m_errdat[i]));
      chk($sformatf("%s.u%0d.cnt", ph, i), 64'(o_cnt[i]), exp_cnt(i));
      chk($sformatf("%s.u%0d.hist", ph, i), 64'(o_hist[i]), exp_hist(i));
    end
  endtask

  task automatic cyc(input string ph);
    @(posedge usclk);
    #1;
    model_edge();
    compare_all(ph);
  endtask

  // Asserts reset between edges, checks the immediate clear, holds across an edge, releases.
  task automatic do_reset(input string ph);
    #2 sso_srst_n = 1'b0;
    #1;
    model_reset();
    compare_all({ph, ".now"});
    @(posedge usclk);
    #1;
    compare_all({ph, ".hold"});
    @(negedge usclk);
    sso_srst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset("rst0");

    // Idle after reset
    for (int c = 0; c < 3; c++) cyc("idle");
    chk("idle.vld4", 64'(o_vld[0]), 64'(0));

    // Streaming select on the 4-way instance
    rd_dat_s3 = {6'h13, 6'h12, 6'h11, 6'h10};
    rd_par_s3 = '0;
    for (int k = 0; k < 4; k++) begin
      rd_vld_s2 = 1'b1;
      adr_s2    = 2'(k);
      cyc("strm");
      if (k >= 1) chk("strm.dat", 64'(o_dat[0]), 64'(6'h10 + k - 1));
    end
    rd_vld_s2 = 1'b0;
    cyc("strm");
    chk("strm.last", 64'(o_dat[0]), 64'h13);
    cyc("strm");
    chk("strm.vldoff", 64'(o_vld[0]), 64'(0));
    chk("strm.cnt", 64'(o_cnt[0]), 64'(4));
    chk("strm.h0", 64'(o_hist[0][5:0]), 64'h13);

    // Sticky error: first error on way 2 kept, later error on way 1 dropped
    rd_vld_s2 = 1'b1; adr_s2 = 2'd2;
    cyc("stk");
    rd_dat_s3 = {6'h00, 6'h2A, 6'h00, 6'h00}; rd_par_s3 = 4'b0100;
    rd_vld_s2 = 1'b1; adr_s2 = 2'd1;
    cyc("stk");
    rd_dat_s3 = {6'h00, 6'h00, 6'h15, 6'h00}; rd_par_s3 = 4'b0010;
    rd_vld_s2 = 1'b0;
    cyc("stk");
    chk("stk.errv", 64'(o_errv[0]), 64'(1));
    chk("stk.way", 64'(o_errway[0]), 64'(2));
    chk("stk.dat", 64'(o_errdat[0]), 64'h2A);
    rd_par_s3 = '0; err_clr = 1'b1;
    cyc("stk");
    err_clr = 1'b0;
    chk("stk.clr", 64'(o_errv[0]), 64'(0));

    // Clear colliding with a new error while held: set wins
    rd_vld_s2 = 1'b1; adr_s2 = 2'd0;
    cyc("col");
    rd_par_s3 = 4'b0001; rd_vld_s2 = 1'b1; adr_s2 = 2'd3;
    cyc("col");
    chk("col.held", 64'(o_errway[0]), 64'(0));
    rd_dat_s3 = {6'h05, 18'h0}; rd_par_s3 = 4'b1000; err_clr = 1'b1; rd_vld_s2 = 1'b0;
    cyc("col");
    chk("col.errv", 64'(o_errv[0]), 64'(1));
    chk("col.way", 64'(o_errway[0]), 64'(3));
    chk("col.dat", 64'(o_errdat[0]), 64'h05);
    rd_par_s3 = '0;
    cyc("col");
    err_clr = 1'b0;
    rd_vld_s2 = 1'b1; adr_s2 = 2'd1;
    cyc("unsel");
    rd_par_s3 = 4'b1101; rd_dat_s3 = 24'h123456; rd_vld_s2 = 1'b0;
    cyc("unsel");
    chk("unsel.errv", 64'(o_errv[0]), 64'(0));
    chk("unsel.vld4", 64'(o_vld[0]), 64'(1));

    // History wrap and out-of-range select on the 3-way instance
    rd_par_s3 = '0;
    do_reset("rst1");
    for (int i = 1; i <= 13; i++) begin
      rd_vld_s2 = (i <= 12);
      adr_s2    = 2'((i - 1) % 3);
      rd_dat_s3 = {4{6'(i - 1)}};
      cyc("hist");
    end
    rd_vld_s2 = 1'b0;
    chk("hist.cnt", 64'(o_cnt[1]), 64'(10));
    chk("hist.h0", 64'(o_hist[1][5:0]), 64'(12));
    chk("hist.h9", 64'(o_hist[1][59:54]), 64'(3));
    rd_vld_s2 = 1'b1; adr_s2 = 2'd3; rd_dat_s3 = {4{6'h3F}};
    cyc("oor");
    rd_vld_s2 = 1'b0;
    cyc("oor");
    chk("oor.dat", 64'(o_dat[1]), 64'(0));
    chk("oor.errv", 64'(o_errv[1]), 64'(1));
    chk("oor.way", 64'(o_errway[1]), 64'(3));

    // Reset with a beat sitting at s3
    rd_vld_s2 = 1'b1; adr_s2 = 2'd1;
    cyc("mid");
    do_reset("rst2");
    rd_vld_s2 = 1'b1; adr_s2 = 2'd2;
    cyc("mid");
    chk("mid.vld1", 64'(o_vld[0]), 64'(0));
    rd_vld_s2 = 1'b0; rd_dat_s3 = {4{6'h3C}};
    cyc("mid");
    chk("mid.vld2", 64'(o_vld[0]), 64'(1));
    chk("mid.dat", 64'(o_dat[0]), 64'h3C);
    chk("mid.cnt", 64'(o_cnt[0]), 64'(1));

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rd_vld_s2 = ($urandom_range(0, 3) != 0);
      adr_s2    = 2'($urandom);
      rd_dat_s3 = 24'($urandom);
      rd_par_s3 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      err_clr   = ($urandom_range(0, 7) == 0);
      cyc("rnd");
      if ($urandom_range(0, 299) == 0) do_reset("rrst");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
